// File: rtl/sys_cmd_responder.sv
// sys_cmd_responder: turns host command frames into RF/ALU strobes and response bytes; define CMD_TIMEOUT_EN to abort stalled frames
module sys_cmd_responder #(
    parameter int WIDTH_REG      = 8,
    parameter int ADDR           = 4,
    parameter int fun            = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   i_REF_CLK,
    input  logic                   i_RST,
    input  logic [WIDTH_REG-1:0]   i_RX_DATA,
    input  logic                   i_RX_VALID,
    output logic [ADDR-1:0]        o_RF_ADDR,
    output logic [WIDTH_REG-1:0]   o_RF_WR_DATA,
    output logic                   o_RF_WR_EN,
    output logic                   o_RF_RD_EN,
    input  logic [WIDTH_REG-1:0]   i_RF_RD_DATA,
    input  logic                   i_RF_RD_VALID,
    output logic [fun-1:0]         o_ALU_FUN,
    output logic                   o_ALU_EN,
    output logic                   o_ALU_CLK_EN,
    input  logic [2*WIDTH_REG-1:0] i_ALU_OUT,
    input  logic                   i_ALU_VALID,
    output logic [WIDTH_REG-1:0]   o_TX_DATA,
    output logic                   o_TX_VALID,
    input  logic                   i_TX_READY,
    output logic                   o_DROP
);
    localparam logic [WIDTH_REG-1:0] CMD_WR  = WIDTH_REG'(8'hAA);
    localparam logic [WIDTH_REG-1:0] CMD_RD  = WIDTH_REG'(8'hBB);
    localparam logic [WIDTH_REG-1:0] CMD_ALU = WIDTH_REG'(8'hCC);
    localparam logic [WIDTH_REG-1:0] CMD_FUN = WIDTH_REG'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT,
        TX_LSB, TX_MSB, TX_ONE
    } state_t;

    state_t                 state, state_d;
    logic [ADDR-1:0]        addr_d;
    logic [WIDTH_REG-1:0]   wr_data_d;
    logic [fun-1:0]         fun_d;
    logic [2*WIDTH_REG-1:0] result, result_d;
    logic                   wr_en_d, rd_en_d, alu_en_d, clk_en_q, clk_en_d, drop_d;
    logic                   collecting, timeout;

    assign collecting = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};

`ifdef CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge i_REF_CLK) begin
        if (i_RST || i_RX_VALID || !collecting) cnt <= '0;
        else cnt <= cnt + CW'(1);
    end
    assign timeout = collecting && !i_RX_VALID && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // The gate opens combinationally on the function byte so the ALU clock runs before o_ALU_EN.
    assign o_ALU_CLK_EN = clk_en_q || (state == ALU_FUN && i_RX_VALID && !i_RST);
    assign o_TX_VALID   = state inside {TX_LSB, TX_MSB, TX_ONE};
    assign o_TX_DATA    = !o_TX_VALID ? '0 :
                          state == TX_MSB ? result[2*WIDTH_REG-1:WIDTH_REG] : result[WIDTH_REG-1:0];

    always_comb begin
        state_d   = state;
        addr_d    = o_RF_ADDR;
        wr_data_d = o_RF_WR_DATA;
        fun_d     = o_ALU_FUN;
        result_d  = result;
        clk_en_d  = clk_en_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        drop_d    = i_RX_VALID && state != IDLE && !collecting;
        case (state)
            IDLE: if (i_RX_VALID)
                state_d = i_RX_DATA == CMD_WR  ? WR_ADDR :
                          i_RX_DATA == CMD_RD  ? RD_ADDR :
                          i_RX_DATA == CMD_ALU ? ALU_A   :
                          i_RX_DATA == CMD_FUN ? ALU_FUN : IDLE;
            WR_ADDR: if (i_RX_VALID) begin
                addr_d  = i_RX_DATA[ADDR-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (i_RX_VALID) begin
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = IDLE;
            end
            RD_ADDR: if (i_RX_VALID) begin
                addr_d  = i_RX_DATA[ADDR-1:0];
                rd_en_d = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (i_RF_RD_VALID) begin
                result_d = {{WIDTH_REG{1'b0}}, i_RF_RD_DATA};
                state_d  = TX_ONE;
            end
            ALU_A: if (i_RX_VALID) begin
                addr_d    = '0;
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = ALU_B;
            end
            ALU_B: if (i_RX_VALID) begin
                addr_d    = ADDR'(1);
                wr_data_d = i_RX_DATA;
                wr_en_d   = 1'b1;
                state_d   = ALU_FUN;
            end
            ALU_FUN: if (i_RX_VALID) begin
                fun_d    = i_RX_DATA[fun-1:0];
                alu_en_d = 1'b1;
                clk_en_d = 1'b1;
                state_d  = ALU_WAIT;
            end
            ALU_WAIT: if (i_ALU_VALID) begin
                result_d = i_ALU_OUT;
                clk_en_d = 1'b0;
                state_d  = TX_LSB;
            end
            TX_LSB: if (i_TX_READY) state_d = TX_MSB;
            TX_MSB, TX_ONE: if (i_TX_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            drop_d  = 1'b1;
        end
    end

    always_ff @(posedge i_REF_CLK) begin
        if (i_RST) begin
            state        <= IDLE;
            o_RF_ADDR    <= '0;
            o_RF_WR_DATA <= '0;
            o_RF_WR_EN   <= 1'b0;
            o_RF_RD_EN   <= 1'b0;
            o_ALU_FUN    <= '0;
            o_ALU_EN     <= 1'b0;
            clk_en_q     <= 1'b0;
            o_DROP       <= 1'b0;
            result       <= '0;
        end else begin
            state        <= state_d;
            o_RF_ADDR    <= addr_d;
            o_RF_WR_DATA <= wr_data_d;
            o_RF_WR_EN   <= wr_en_d;
            o_RF_RD_EN   <= rd_en_d;
            o_ALU_FUN    <= fun_d;
            o_ALU_EN     <= alu_en_d;
            clk_en_q     <= clk_en_d;
            o_DROP       <= drop_d;
            result       <= result_d;
        end
    end
endmodule
